led_tick_ctrl: RTL
==================

LED_TICK_CTRL -- requirements
Module: led_tick_ctrl

Interface
REQ-001 Parameter DIV0, default 12_500_000, base step period in clk cycles; legal values are integers >= 8.
REQ-002 Parameter DEB_LEN, default 1_000_000, number of stable cycles a button needs before acceptance; legal values are integers >= 2.
REQ-003 Port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 Port rs, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port btn_run, input, 1 bit: raw run/stop pushbutton, asynchronous to clk, high when pressed.
REQ-006 Port btn_step, input, 1 bit: raw single-step pushbutton, asynchronous to clk, high when pressed.
REQ-007 Port spd, input, 2 bits: speed select, sampled only as defined in REQ-016.
REQ-008 Port tick, output, 1 bit: one-cycle step-enable pulse to the downstream LED shifter.
REQ-009 Port running, output, 1 bit: high while the FSM is in RUN.
REQ-010 Port spd_q, output, 2 bits: the speed code currently in use.

Function
REQ-011 Each button SHALL pass through a 2-flop synchronizer, so the synchronized level s2 equals the raw input delayed 2 cycles.
REQ-012 Debounce per button: while s2 != db, cnt SHALL increment; when s2 == db, cnt SHALL clear; when cnt == DEB_LEN-1 and s2 != db, db SHALL take s2 and cnt SHALL clear.
REQ-013 A press event SHALL be a 1-cycle pulse in the cycle after db rises; a db fall SHALL produce no event.
REQ-014 FSM states SHALL be STOP and RUN; a run press SHALL toggle the state on the clock edge that samples the event.
REQ-015 Step period P SHALL be DIV0 >> spd_q (DIV0, DIV0/2, DIV0/4 or DIV0/8), using integer truncation.
REQ-016 spd_q SHALL load spd on a STOP->RUN transition and on every edge that asserts tick in RUN; at all other times spd_q SHALL hold.
REQ-017 On entry to RUN, the down-counter SHALL load P-1 using the newly loaded spd_q.
REQ-018 In RUN, the counter SHALL decrement each cycle; at count 0, tick SHALL assert on the next edge and the counter SHALL reload P-1 on that same edge.
REQ-019 tick SHALL be registered, so the first tick is high exactly P cycles after the RUN-entry edge, and subsequent ticks follow every P cycles.
REQ-020 In STOP, the counter SHALL hold and tick SHALL stay low except for single steps.
REQ-021 A step press in STOP SHALL assert tick for exactly 1 cycle, on the edge after the event; step presses in RUN SHALL be ignored.
REQ-022 If a run event and a step event occur in the same cycle, the run event SHALL win and the step event SHALL be discarded.
REQ-023 RUN->STOP SHALL take effect immediately: a tick due in the same cycle SHALL be suppressed, and the counter SHALL freeze.
REQ-024 A bounce shorter than DEB_LEN cycles SHALL produce no event; a held button SHALL produce exactly one event.

Reset
REQ-025 While rs is high, all registers SHALL clear asynchronously: state STOP, tick 0, running 0, spd_q 00, counters 0, db 0, synchronizers 0.
REQ-026 After rs falls, the block SHALL remain in STOP until a debounced run press; an asserted rs mid-RUN SHALL abort any pending tick.

Verification (DIV0=8, DEB_LEN=4)
REQ-027 Release rs with btn_run held high from reset -> running rises 2+4+1 cycles later, and the first tick follows 8 cycles after that.
REQ-028 RUN with spd=2'b11 -> tick every 1 cycle; change spd to 00 mid-period -> the new period of 8 applies only after the next tick, and spd_q updates on that tick.
REQ-029 btn_run pulses high for 3 cycles, low for 2, then high for 3 -> no state change and tick stays 0.
REQ-030 In STOP, one clean step press -> exactly one tick pulse and running stays 0; the same press in RUN -> the tick cadence is unchanged.
REQ-031 Run and step presses align to the same cycle while in STOP -> RUN is entered and no extra tick is produced.
REQ-032 Assert rs 3 cycles before an expected tick -> tick stays 0, all outputs read 0, and the state is STOP.

Source files
------------

// File: rtl/led_tick_ctrl.sv
// Run/stop and single-step controller producing a step-enable tick for an LED shifter.
// Buttons are synchronized and debounced; speed is latched at run entry and on each tick.

module led_tick_debounce #(
  parameter int unsigned DEB_LEN = 1_000_000
) (
  input  logic clk,
  input  logic rs,
  input  logic btn,
  output logic press_c
);

  localparam int unsigned DW = (DEB_LEN > 2) ? $clog2(DEB_LEN) : 1;

  logic          s1;
  logic          s2;
  logic          db;
  logic          db_d;
  logic [DW-1:0] cnt;

  // Two-flop synchronizer, stability counter and debounced level.
  always_ff @(posedge clk or posedge rs) begin
    if (rs) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      db   <= 1'b0;
      db_d <= 1'b0;
      cnt  <= '0;
    end else begin
      s1   <= btn;
      s2   <= s1;
      db_d <= db;
      if (s2 == db) begin
        cnt <= '0;
      end else if (cnt == DW'(DEB_LEN - 1)) begin
        db  <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + DW'(1);
      end
    end
  end

  // Press event is the cycle after the debounced level rises; releases are silent.
  assign press_c = db & ~db_d;

endmodule

module led_tick_ctrl #(
  parameter int unsigned DIV0    = 12_500_000,
  parameter int unsigned DEB_LEN = 1_000_000
) (
  input  logic       clk,
  input  logic       rs,
  input  logic       btn_run,
  input  logic       btn_step,
  input  logic [1:0] spd,
  output logic       tick,
  output logic       running,
  output logic [1:0] spd_q
);

  localparam int unsigned CW = $clog2(DIV0);

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t          state_q;
  state_t          state_nx;
  logic            tick_nx;
  logic            running_nx;
  logic [1:0]      spd_nx;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_nx;
  logic            run_ev_c;
  logic            step_ev_c;

  led_tick_debounce #(.DEB_LEN(DEB_LEN)) u_db_run (
    .clk     (clk),
    .rs      (rs),
    .btn     (btn_run),
    .press_c (run_ev_c)
  );

  led_tick_debounce #(.DEB_LEN(DEB_LEN)) u_db_step (
    .clk     (clk),
    .rs      (rs),
    .btn     (btn_step),
    .press_c (step_ev_c)
  );

  // Reload value P-1 for a given speed code; DIV0 >= 8 keeps P >= 1.
  function automatic logic [CW-1:0] period_m1(input logic [1:0] s);
    return CW'(DIV0 >> s) - CW'(1);
  endfunction

  always_ff @(posedge clk or posedge rs) begin
    if (rs) begin
      state_q <= ST_STOP;
      tick    <= 1'b0;
      running <= 1'b0;
      spd_q   <= 2'b00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nx;
      tick    <= tick_nx;
      running <= running_nx;
      spd_q   <= spd_nx;
      cnt_q   <= cnt_nx;
    end
  end

  // Run press beats a simultaneous step; stopping suppresses a tick due this cycle.
  always_comb begin
    state_nx = state_q;
    tick_nx  = 1'b0;
    spd_nx   = spd_q;
    cnt_nx   = cnt_q;
    case (state_q)
      ST_STOP: begin
        if (run_ev_c) begin
          state_nx = ST_RUN;
          spd_nx   = spd;
          cnt_nx   = period_m1(spd);
        end else if (step_ev_c) begin
          tick_nx = 1'b1;
        end
      end
      ST_RUN: begin
        if (run_ev_c) begin
          state_nx = ST_STOP;
        end else if (cnt_q == '0) begin
          tick_nx = 1'b1;
          spd_nx  = spd;
          cnt_nx  = period_m1(spd);
        end else begin
          cnt_nx = cnt_q - CW'(1);
        end
      end
    endcase
    running_nx = (state_nx == ST_RUN);
  end

endmodule
